// File: rtl/forwarding_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: EX-stage forward selects, load-use
// stall/bubble controls and a saturating stall counter, tracked via shadow EX/MEM state.
module forwarding_hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             ID_Rs_In,
  input  logic [4:0]             ID_Rt_In,
  input  logic                   ID_UsaRs_In,
  input  logic                   ID_UsaRt_In,
  input  logic                   ID_ALUSrc_In,
  input  logic                   ID_RegWrite_In,
  input  logic                   ID_MemRead_In,
  input  logic [4:0]             ID_Dest_In,
  input  logic                   Flush_In,
  output logic [1:0]             Saida_ForwardA_Out,
  output logic [1:0]             Saida_ForwardB_Out,
  output logic [1:0]             Saida_ForwardStore_Out,
  output logic                   PC_Write_Out,
  output logic                   IFID_Write_Out,
  output logic                   IDEX_Bubble_Out,
  output logic [STALL_CNT_W-1:0] Stall_Count_Out
);

  // WB-stage producers need no tracking: the register file writes before it reads.
  logic                   ex_valid, ex_rw, ex_mr;
  logic [4:0]             ex_dest;
  logic                   mem_valid, mem_rw;
  logic [4:0]             mem_dest;

  logic [1:0]             fwd_a, fwd_b, fwd_s;
  logic [STALL_CNT_W-1:0] stall_cnt;

  logic                   ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic                   load_use, stall, bubble;
  logic [1:0]             sel_rs, sel_rt;
  logic [1:0]             fwd_a_d, fwd_b_d, fwd_s_d;

  always_comb begin
    ex_hit_rs  = ex_valid  & ex_rw  & (ex_dest  == ID_Rs_In) & (ID_Rs_In != 5'd0);
    ex_hit_rt  = ex_valid  & ex_rw  & (ex_dest  == ID_Rt_In) & (ID_Rt_In != 5'd0);
    mem_hit_rs = mem_valid & mem_rw & (mem_dest == ID_Rs_In) & (ID_Rs_In != 5'd0);
    mem_hit_rt = mem_valid & mem_rw & (mem_dest == ID_Rt_In) & (ID_Rt_In != 5'd0);

    load_use = ex_mr & ((ID_UsaRs_In & ex_hit_rs) | (ID_UsaRt_In & ex_hit_rt));
    stall    = load_use & ~Flush_In;
    bubble   = stall | Flush_In;

    // Youngest producer wins; a load still in EX cannot supply a value yet.
    sel_rs = 2'b00;
    if (ex_hit_rs & ~ex_mr) sel_rs = 2'b10;
    else if (mem_hit_rs)    sel_rs = 2'b11;
    sel_rt = 2'b00;
    if (ex_hit_rt & ~ex_mr) sel_rt = 2'b10;
    else if (mem_hit_rt)    sel_rt = 2'b11;

    fwd_a_d = ID_UsaRs_In                   ? sel_rs : 2'b00;
    fwd_b_d = (ID_UsaRt_In & ~ID_ALUSrc_In) ? sel_rt : 2'b00;
    fwd_s_d = ID_UsaRt_In                   ? sel_rt : 2'b00;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_dest   <= 5'd0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_dest  <= 5'd0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      fwd_s     <= 2'b00;
      stall_cnt <= '0;
    end else begin
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_dest  <= ex_dest;
      ex_valid  <= ~bubble;
      ex_rw     <= ID_RegWrite_In;
      ex_mr     <= ID_MemRead_In;
      ex_dest   <= ID_Dest_In;
      fwd_a     <= bubble ? 2'b00 : fwd_a_d;
      fwd_b     <= bubble ? 2'b00 : fwd_b_d;
      fwd_s     <= bubble ? 2'b00 : fwd_s_d;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign Saida_ForwardA_Out     = fwd_a;
  assign Saida_ForwardB_Out     = fwd_b;
  assign Saida_ForwardStore_Out = fwd_s;
  assign PC_Write_Out           = ~stall;
  assign IFID_Write_Out         = ~stall;
  assign IDEX_Bubble_Out        = bubble;
  assign Stall_Count_Out        = stall_cnt;

endmodule
